// File: rtl/context_stack_sequencer_pkg.sv
// Shared types for the context save/restore sequencer: FSM states and error codes.
package maku_ctx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAVE,
    ST_SAVE_DRAIN,
    ST_RESTORE,
    ST_RESTORE_DRAIN,
    ST_FINISH
  } ctx_state_t;

  typedef enum logic [1:0] {
    CTX_OK  = 2'b00,
    CTX_OVF = 2'b01,
    CTX_UDF = 2'b10
  } ctx_err_t;

endpackage

// File: rtl/context_stack_sequencer_if.sv
// Bundle between the sequencer, the core's register file and its stack-controller port.
interface context_stack_sequencer_if
  import maku_ctx_pkg::*;
#(
  parameter int unsigned NUM_REGS = 16
);
  localparam int unsigned REG_AW = $clog2(NUM_REGS);
  localparam int unsigned CNT_W  = $clog2(NUM_REGS + 1);

  logic              save_req;
  logic              restore_req;
  logic              busy;
  logic              done;
  logic [1:0]        err_code;
  logic [CNT_W-1:0]  xfer_count;
  logic [REG_AW-1:0] rf_raddr;
  logic [31:0]       rf_rdata;
  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [31:0]       rf_wdata;
  logic              stk_push;
  logic              stk_pop;
  logic [31:0]       stk_wdata;
  logic [31:0]       stk_rdata;
  logic              stk_overflow;
  logic              stk_underflow;

  modport master (
    input  save_req, restore_req, rf_rdata, stk_rdata, stk_overflow, stk_underflow,
    output busy, done, err_code, xfer_count, rf_raddr, rf_we, rf_waddr, rf_wdata,
           stk_push, stk_pop, stk_wdata
  );

  modport slave (
    output save_req, restore_req, rf_rdata, stk_rdata, stk_overflow, stk_underflow,
    input  busy, done, err_code, xfer_count, rf_raddr, rf_we, rf_waddr, rf_wdata,
           stk_push, stk_pop, stk_wdata
  );

endinterface

// File: rtl/context_stack_sequencer.sv
// Interrupt entry/exit engine: pushes NUM_REGS registers to the hardware stack on save,
// pops them back in reverse order on restore, aborting on stack overflow/underflow.
module context_stack_sequencer
  import maku_ctx_pkg::*;
#(
  parameter int unsigned NUM_REGS = 16
) (
  input logic                       clk,
  input logic                       rst_n,
  context_stack_sequencer_if.master bus
);

  localparam int unsigned REG_AW = $clog2(NUM_REGS);
  localparam int unsigned CNT_W  = $clog2(NUM_REGS + 1);
  localparam logic [REG_AW-1:0] LAST_IDX = REG_AW'(NUM_REGS - 1);

  ctx_state_t        state_q, state_d;
  logic [REG_AW-1:0] idx_q, idx_d;
  logic              strobe_q, strobe_d;
  ctx_err_t          err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              busy_c;
  logic              done_c;
  logic [REG_AW-1:0] rf_raddr_c;
  logic              rf_we_c;
  logic [REG_AW-1:0] rf_waddr_c;
  logic [31:0]       rf_wdata_c;
  logic              push_c;
  logic              pop_c;
  logic [31:0]       stk_wdata_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      strobe_q <= 1'b0;
      err_q    <= CTX_OK;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      strobe_q <= strobe_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  // strobe_q marks a push/pop issued last cycle whose flag (or pop data) arrives now.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    strobe_d    = 1'b0;
    err_d       = err_q;
    cnt_d       = cnt_q;
    busy_c      = 1'b1;
    done_c      = 1'b0;
    rf_raddr_c  = '0;
    rf_we_c     = 1'b0;
    rf_waddr_c  = '0;
    rf_wdata_c  = '0;
    push_c      = 1'b0;
    pop_c       = 1'b0;
    stk_wdata_c = '0;

    case (state_q)
      ST_IDLE: begin
        busy_c = 1'b0;
        if (bus.save_req) begin
          state_d = ST_SAVE;
          idx_d   = '0;
          err_d   = CTX_OK;
          cnt_d   = '0;
        end else if (bus.restore_req) begin
          state_d = ST_RESTORE;
          idx_d   = LAST_IDX;
          err_d   = CTX_OK;
          cnt_d   = '0;
        end
      end

      ST_SAVE: begin
        if (bus.stk_overflow) begin
          err_d   = CTX_OVF;
          state_d = ST_FINISH;
        end else begin
          rf_raddr_c  = idx_q;
          push_c      = 1'b1;
          stk_wdata_c = bus.rf_rdata;
          strobe_d    = 1'b1;
          if (strobe_q) cnt_d = cnt_q + CNT_W'(1);
          if (idx_q == LAST_IDX) state_d = ST_SAVE_DRAIN;
          else                   idx_d   = idx_q + REG_AW'(1);
        end
      end

      ST_SAVE_DRAIN: begin
        if (bus.stk_overflow) err_d = CTX_OVF;
        else                  cnt_d = cnt_q + CNT_W'(1);
        state_d = ST_FINISH;
      end

      ST_RESTORE: begin
        if (bus.stk_underflow) begin
          err_d   = CTX_UDF;
          state_d = ST_FINISH;
        end else begin
          pop_c    = 1'b1;
          strobe_d = 1'b1;
          // Data returned now belongs to the pop issued for the previous (higher) index.
          if (strobe_q) begin
            rf_we_c    = 1'b1;
            rf_waddr_c = idx_q + REG_AW'(1);
            rf_wdata_c = bus.stk_rdata;
            cnt_d      = cnt_q + CNT_W'(1);
          end
          if (idx_q == '0) state_d = ST_RESTORE_DRAIN;
          else             idx_d   = idx_q - REG_AW'(1);
        end
      end

      ST_RESTORE_DRAIN: begin
        if (bus.stk_underflow) begin
          err_d = CTX_UDF;
        end else begin
          rf_we_c    = 1'b1;
          rf_waddr_c = idx_q;
          rf_wdata_c = bus.stk_rdata;
          cnt_d      = cnt_q + CNT_W'(1);
        end
        state_d = ST_FINISH;
      end

      ST_FINISH: begin
        done_c  = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.busy       = busy_c;
  assign bus.done       = done_c;
  assign bus.err_code   = err_q;
  assign bus.xfer_count = cnt_q;
  assign bus.rf_raddr   = rf_raddr_c;
  assign bus.rf_we      = rf_we_c;
  assign bus.rf_waddr   = rf_waddr_c;
  assign bus.rf_wdata   = rf_wdata_c;
  assign bus.stk_push   = push_c;
  assign bus.stk_pop    = pop_c;
  assign bus.stk_wdata  = stk_wdata_c;

endmodule

// File: tb/tb_context_stack_sequencer.sv
// Directed bench: sequencer against a 1024-entry stack controller model and a 16x32 register file.
module tb_context_stack_sequencer;

  localparam int unsigned NREG  = 16;
  localparam int unsigned SSIZE = 1024;

  logic clk;
  logic rst_n;

  context_stack_sequencer_if #(.NUM_REGS(NREG)) bus ();

  context_stack_sequencer #(.NUM_REGS(NREG)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- register file model ----------------
  logic [31:0] rf [NREG];
  logic        rf_init, rf_clr;

  always @(posedge clk) begin
    if (rf_init) begin
      for (int i = 0; i < int'(NREG); i++) rf[i] <= 32'hA000_0000 + 32'(i);
    end else if (rf_clr) begin
      for (int i = 0; i < int'(NREG); i++) rf[i] <= '0;
    end else if (bus.rf_we) begin
      rf[bus.rf_waddr] <= bus.rf_wdata;
    end
  end
  assign bus.rf_rdata = rf[bus.rf_raddr];

  // ---------------- stack controller model ----------------
  // The top slot is reserved, so a push is refused once SSIZE-1 words are held.
  logic [31:0] stk_mem [SSIZE];
  int unsigned sp;
  logic        ovf_q, udf_q;
  logic [31:0] srd_q;
  logic        ld_sp;
  int unsigned ld_val;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp    <= 0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
      srd_q <= '0;
    end else begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
      if (ld_sp) begin
        sp <= ld_val;
      end else if (bus.stk_push) begin
        if (sp >= SSIZE - 1) ovf_q <= 1'b1;
        else begin
          stk_mem[sp] <= bus.stk_wdata;
          sp <= sp + 1;
        end
      end else if (bus.stk_pop) begin
        if (sp == 0) udf_q <= 1'b1;
        else begin
          srd_q <= stk_mem[sp-1];
          sp <= sp - 1;
        end
      end
    end
  end
  assign bus.stk_rdata     = srd_q;
  assign bus.stk_overflow  = ovf_q;
  assign bus.stk_underflow = udf_q;

  // ---------------- monitor ----------------
  int          cyc;
  int          base;
  int          push_n, pop_n, wr_n, done_n, viol_n;
  int          push_cyc [256];
  logic [31:0] push_dat [256];
  int          pop_cyc  [256];
  int          wr_cyc   [256];
  logic [3:0]  wr_addr  [256];
  logic [31:0] wr_dat   [256];
  int          done_cyc;
  logic [1:0]  done_err;
  logic [4:0]  done_cnt;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    push_n = 0; pop_n = 0; wr_n = 0; done_n = 0; viol_n = 0;
    done_cyc = 0; done_err = '0; done_cnt = '0;
  end

  always @(negedge clk) begin
    if (bus.stk_push && (bus.stk_pop || bus.rf_we)) viol_n = viol_n + 1;
    if (bus.stk_push && push_n < 256) begin
      push_cyc[push_n] = cyc - base;
      push_dat[push_n] = bus.stk_wdata;
      push_n = push_n + 1;
    end
    if (bus.stk_pop && pop_n < 256) begin
      pop_cyc[pop_n] = cyc - base;
      pop_n = pop_n + 1;
    end
    if (bus.rf_we && wr_n < 256) begin
      wr_cyc[wr_n]  = cyc - base;
      wr_addr[wr_n] = bus.rf_waddr;
      wr_dat[wr_n]  = bus.rf_wdata;
      wr_n = wr_n + 1;
    end
    if (bus.done) begin
      done_cyc = cyc - base;
      done_err = bus.err_code;
      done_cnt = bus.xfer_count;
      done_n   = done_n + 1;
    end
  end

  // ---------------- checking ----------------
  int total, bad;
  int pb, ob, wb, db;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic load_sp(input int unsigned v);
    @(posedge clk); #1;
    ld_val = v; ld_sp = 1'b1;
    @(posedge clk); #1;
    ld_sp = 1'b0;
  endtask

  task automatic rf_ctl(input logic init, input logic clr);
    @(posedge clk); #1;
    rf_init = init; rf_clr = clr;
    @(posedge clk); #1;
    rf_init = 1'b0; rf_clr = 1'b0;
  endtask

  task automatic start_seq(input logic sv, input logic rs);
    @(posedge clk); #1;
    base = cyc;
    pb = push_n; ob = pop_n; wb = wr_n; db = done_n;
    bus.save_req = sv; bus.restore_req = rs;
    @(posedge clk); #1;
    bus.save_req = 1'b0; bus.restore_req = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (done_n == db && k < 60) begin
      @(negedge clk);
      k++;
    end
    check({tag, " done seen"}, 32'(done_n - db), 32'd1);
    @(negedge clk);
    check({tag, " busy after"}, 32'(bus.busy), 32'd0);
  endtask

  int nb;

  initial begin
    total = 0; bad = 0;
    base = 0; pb = 0; ob = 0; wb = 0; db = 0;
    rst_n = 1'b0;
    bus.save_req = 1'b0; bus.restore_req = 1'b0;
    rf_init = 1'b0; rf_clr = 1'b0; ld_sp = 1'b0; ld_val = 0;
    #2;
    check("rst busy", 32'(bus.busy), 32'd0);
    check("rst done", 32'(bus.done), 32'd0);
    check("rst err", 32'(bus.err_code), 32'd0);
    check("rst cnt", 32'(bus.xfer_count), 32'd0);
    check("rst push", 32'(bus.stk_push), 32'd0);
    check("rst pop", 32'(bus.stk_pop), 32'd0);
    check("rst we", 32'(bus.rf_we), 32'd0);
    @(posedge clk); #3 rst_n = 1'b1;

    // 1: full save onto an empty stack
    rf_ctl(1'b1, 1'b0);
    start_seq(1'b1, 1'b0);
    wait_done("save");
    check("save pushes", 32'(push_n - pb), 32'd16);
    nb = 0;
    for (int i = 0; i < 16; i++)
      if (push_cyc[pb+i] != i + 1 || push_dat[pb+i] != 32'hA000_0000 + 32'(i)) nb++;
    check("save order", 32'(nb), 32'd0);
    check("save done cyc", 32'(done_cyc), 32'd18);
    check("save err", 32'(done_err), 32'd0);
    check("save cnt", 32'(done_cnt), 32'd16);
    check("save sp", sp, 32'd16);
    check("save top word", stk_mem[15], 32'hA000_000F);

    // 2: full restore into a cleared register file
    rf_ctl(1'b0, 1'b1);
    start_seq(1'b0, 1'b1);
    wait_done("rest");
    check("rest pops", 32'(pop_n - ob), 32'd16);
    check("rest first pop", 32'(pop_cyc[ob]), 32'd1);
    check("rest last pop", 32'(pop_cyc[ob+15]), 32'd16);
    check("rest writes", 32'(wr_n - wb), 32'd16);
    nb = 0;
    for (int k = 0; k < 16; k++)
      if (wr_cyc[wb+k] != k + 2 || wr_addr[wb+k] != 4'(15 - k) ||
          wr_dat[wb+k] != 32'hA000_0000 + 32'(15 - k)) nb++;
    check("rest order", 32'(nb), 32'd0);
    nb = 0;
    for (int i = 0; i < 16; i++) if (rf[i] != 32'hA000_0000 + 32'(i)) nb++;
    check("rest rf", 32'(nb), 32'd0);
    check("rest done cyc", 32'(done_cyc), 32'd18);
    check("rest err", 32'(done_err), 32'd0);
    check("rest cnt", 32'(done_cnt), 32'd16);
    check("rest sp", sp, 32'd0);

    // 3: overflow after 8 successful pushes
    load_sp(1015);
    start_seq(1'b1, 1'b0);
    wait_done("ovf");
    check("ovf pushes", 32'(push_n - pb), 32'd9);
    check("ovf last push", 32'(push_cyc[pb+8]), 32'd9);
    check("ovf done cyc", 32'(done_cyc), 32'd11);
    check("ovf err", 32'(done_err), 32'd1);
    check("ovf cnt", 32'(done_cnt), 32'd8);
    check("ovf sp", sp, 32'd1023);

    // 4: underflow with 5 words on the stack
    rf_ctl(1'b0, 1'b1);
    load_sp(5);
    start_seq(1'b0, 1'b1);
    wait_done("udf");
    check("udf pops", 32'(pop_n - ob), 32'd6);
    check("udf writes", 32'(wr_n - wb), 32'd5);
    check("udf rf15", rf[15], 32'hA000_0004);
    check("udf rf11", rf[11], 32'hA000_0000);
    check("udf rf10", rf[10], 32'h0);
    check("udf done cyc", 32'(done_cyc), 32'd8);
    check("udf err", 32'(done_err), 32'd2);
    check("udf cnt", 32'(done_cnt), 32'd5);
    check("udf sp", sp, 32'd0);

    // 5: simultaneous requests, then restore_req while busy
    start_seq(1'b1, 1'b1);
    for (int k = 0; k < 60 && done_n == db; k++) begin
      @(posedge clk); #1;
      bus.restore_req = (cyc - base == 5);
    end
    bus.restore_req = 1'b0;
    @(negedge clk);
    check("both busy after", 32'(bus.busy), 32'd0);
    check("both pushes", 32'(push_n - pb), 32'd16);
    check("both pops", 32'(pop_n - ob), 32'd0);
    check("both err", 32'(done_err), 32'd0);
    check("both cnt", 32'(done_cnt), 32'd16);

    // 6: asynchronous reset mid-save
    start_seq(1'b1, 1'b0);
    repeat (5) @(posedge clk);
    #2;
    check("mid push before", 32'(bus.stk_push), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid push", 32'(bus.stk_push), 32'd0);
    check("mid busy", 32'(bus.busy), 32'd0);
    check("mid cnt", 32'(bus.xfer_count), 32'd0);
    check("mid wdata", bus.stk_wdata, 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    pb = push_n;
    repeat (5) @(negedge clk);
    check("post rst pushes", 32'(push_n - pb), 32'd0);
    check("post rst busy", 32'(bus.busy), 32'd0);
    start_seq(1'b1, 1'b0);
    wait_done("resave");
    check("resave pushes", 32'(push_n - pb), 32'd16);
    check("resave done cyc", 32'(done_cyc), 32'd18);
    check("resave err", 32'(done_err), 32'd0);
    check("resave cnt", 32'(done_cnt), 32'd16);

    check("strobe overlap", 32'(viol_n), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/context_stack_sequencer.md
Name: context_stack_sequencer

Overview:
Sequences multi-word context save and restore between one core's register file and its port on the hardware stack controller. This is the interrupt-entry and exit engine.
- On save, it pushes NUM_REGS registers, one per cycle.
- On restore, it pops them back in reverse order.
- It tracks the stack controller's registered overflow/underflow flags, aborts cleanly on either, and reports how many words it transferred.
- One instance sits beside each core (RT and GP).

Parameters:
- NUM_REGS, 16, registers per context frame (2..32).
- REG_AW, $clog2(NUM_REGS), register index width (localparam).
- CNT_W, $clog2(NUM_REGS+1), transfer-count width (localparam).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock, asynchronous, active-low
- save_req  in  1  start-save pulse; sampled only in IDLE
- restore_req  in  1  start-restore pulse; sampled only in IDLE
- busy  out  1  sequence in progress
- done  out  1  one-cycle completion pulse
- err_code  out  2  00 ok, 01 overflow, 10 underflow; valid with done, held until next start
- xfer_count  out  CNT_W  words successfully transferred; valid with done
- rf_raddr  out  REG_AW  register file read index (asynchronous read)
- rf_rdata  in  32  register file read data, same cycle
- rf_we  out  1  register file write enable
- rf_waddr  out  REG_AW  register file write index
- rf_wdata  out  32  register file write data
- stk_push  out  1  stack push strobe
- stk_pop  out  1  stack pop strobe
- stk_wdata  out  32  push data
- stk_rdata  in  32  pop data, valid the cycle after stk_pop
- stk_overflow  in  1  registered flag for the previous-cycle push
- stk_underflow  in  1  registered flag for the previous-cycle pop

Behaviour:
- Reset: state IDLE; all outputs 0; counters 0. Asynchronous reset mid-sequence aborts immediately with no further strobes. The stack controller shares rst_n.
- States: IDLE, SAVE, SAVE_DRAIN, RESTORE, RESTORE_DRAIN, FINISH.
- IDLE:
  - save_req=1 -> SAVE, idx=0.
  - Else restore_req=1 -> RESTORE, idx=NUM_REGS-1.
  - Both high: save wins, restore dropped.
  - Requests outside IDLE are ignored.
  - Starting a sequence clears err_code and xfer_count.
- busy=1 in SAVE, SAVE_DRAIN, RESTORE, RESTORE_DRAIN, FINISH.
- SAVE, each cycle:
  - If stk_overflow=1: no push; err_code<=01; -> FINISH.
  - Else: rf_raddr=idx, stk_push=1, stk_wdata=rf_rdata (combinational).
  - If a push was issued the previous cycle and no overflow, xfer_count++.
  - If idx==NUM_REGS-1 -> SAVE_DRAIN; else idx++.
- SAVE_DRAIN (no push): apply the last push's flag. If overflow, err_code<=01; else xfer_count++. -> FINISH.
- RESTORE, each cycle:
  - If stk_underflow=1: no pop, no write; err_code<=10; -> FINISH.
  - Else: stk_pop=1 for idx.
  - If a pop was issued the previous cycle: rf_we=1, rf_waddr=previous idx, rf_wdata=stk_rdata, xfer_count++.
  - If idx==0 -> RESTORE_DRAIN; else idx--.
- RESTORE_DRAIN: no pop.
  - If stk_underflow: no write, err_code<=10.
  - Else: write idx 0 from stk_rdata, xfer_count++.
  - -> FINISH.
- FINISH: done=1 for one cycle -> IDLE.
- stk_push and stk_pop are never high together. rf_we is never high in a SAVE state.
- Latency, error-free run with save_req sampled at cycle 0:
  - Strobes in cycles 1..N.
  - Drain in cycle N+1.
  - done at N+2.
  - busy low and next request accepted from cycle N+3.

Decomposition:
- Shared package maku_ctx_pkg:
  - ctx_state_t enum.
  - ctx_err_t enum (CTX_OK=2'b00, CTX_OVF=2'b01, CTX_UDF=2'b10).
- Single module; no sub-module warranted.

Test Plan (bench: NUM_REGS=16, with stack_controller STACK_SIZE=1024 and a 16x32 register file model):
- Empty stack, rf[i]=0xA000_0000+i, save_req at cycle 0 -> pushes cycles 1..16 in order 0..15; done at 18; err_code=00; xfer_count=16; stack holds 16 words.
- Clear rf, restore_req -> pops cycles 1..16; rf writes idx 15..0 cycles 2..17; rf[i]=0xA000_0000+i; done at 18; err=00; count=16; stack empty.
- Prefill stack to sp=1015, save -> 8 pushes succeed, 9th flags overflow; no 10th push; done with err_code=01, xfer_count=8.
- Stack holds 5 words, restore -> writes rf15..rf11, 6th pop underflows; no 7th pop; done with err_code=10, xfer_count=5.
- save_req and restore_req high together in IDLE -> save sequence runs; restore_req pulsed during busy -> ignored, no pop.
- rst_n low at cycle 6 of a save -> all outputs 0 immediately; no strobes after release; next save_req accepted normally.
